// File: rtl/multicycle_ctrl.sv
// pa_riscv: shared RV32 ALU operation codes used by the datapath and its controllers.
// Encoding is {funct7b5, funct3} of the matching R-type instruction.
package pa_riscv;
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;
  localparam logic [3:0] ALU_SLT = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0111;
endpackage

// multicycle_ctrl: FSM controller for a multicycle RV32 subset core (lw, sw, R/I ALU, jal, beq).
// Latency: lw 5 cycles, sw/R/I/jal 4, beq 3; illegal instructions abort to FETCH after DECODE.
// Backpressure: none; the FSM advances every cycle. Ports: i_clk, i_arst_n, instruction
// fields (i_op, i_funct3, i_funct7b5), i_zeroFlag in; write strobes, datapath selects,
// immediate format, ALU operation, o_illegal pulse and o_state (debug) out.
module multicycle_ctrl
  import pa_riscv::*;
(
  input  logic       i_clk,
  input  logic       i_arst_n,
  input  logic [6:0] i_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_zeroFlag,
  output logic       o_pcWrite,
  output logic       o_irWrite,
  output logic       o_regWrite,
  output logic       o_memWrite,
  output logic       o_adrSrc,
  output logic [1:0] o_aluSrcA,
  output logic [1:0] o_aluSrcB,
  output logic [1:0] o_resultSrc,
  output logic [1:0] o_immSrc,
  output logic [3:0] o_aluLogicOperation,
  output logic       o_illegal,
  output logic [3:0] o_state
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_EXECI    = 4'd8;
  localparam logic [3:0] S_JAL      = 4'd9;
  localparam logic [3:0] S_BEQ      = 4'd10;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  logic [3:0] state_q;
  logic [3:0] state_d;

  logic is_load, is_store, is_rtype, is_itype, is_jal, is_beq;
  logic funct3_alu_ok;
  logic legal_instr;
  logic [3:0] alu_dec;

  // strobes before reset gating
  logic pc_write, ir_write, reg_write, mem_write;

  assign is_load  = (i_op == OP_LOAD);
  assign is_store = (i_op == OP_STORE);
  assign is_rtype = (i_op == OP_RTYPE);
  assign is_itype = (i_op == OP_ITYPE);
  assign is_jal   = (i_op == OP_JAL);
  assign is_beq   = (i_op == OP_BEQ);

  assign funct3_alu_ok = (i_funct3 == 3'b000) || (i_funct3 == 3'b010) ||
                         (i_funct3 == 3'b100) || (i_funct3 == 3'b110) ||
                         (i_funct3 == 3'b111);

  assign legal_instr = ((is_load || is_store) && (i_funct3 == 3'b010)) ||
                       ((is_rtype || is_itype) && funct3_alu_ok) ||
                       is_jal ||
                       (is_beq && (i_funct3 == 3'b000));

  // funct7b5 only selects SUB for R-type; addi with bit 30 set is still ADD
  always_comb begin
    alu_dec = ALU_ADD;
    case (i_funct3)
      3'b000:  alu_dec = (is_rtype && i_funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_dec = ALU_SLT;
      3'b100:  alu_dec = ALU_XOR;
      3'b110:  alu_dec = ALU_OR;
      3'b111:  alu_dec = ALU_AND;
      default: alu_dec = ALU_ADD;
    endcase
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (!legal_instr)                 state_d = S_FETCH;
        else if (is_load || is_store)     state_d = S_MEMADR;
        else if (is_rtype)                state_d = S_EXECR;
        else if (is_itype)                state_d = S_EXECI;
        else if (is_jal)                  state_d = S_JAL;
        else                              state_d = S_BEQ;
      end
      S_MEMADR:   state_d = is_load ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECR,
      S_EXECI,
      S_JAL:      state_d = S_ALUWB;
      default:    state_d = S_FETCH;  // terminal states and unused codes 11-15
    endcase
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) state_q <= S_FETCH;
    else           state_q <= state_d;
  end

  always_comb begin
    pc_write            = 1'b0;
    ir_write            = 1'b0;
    reg_write           = 1'b0;
    mem_write           = 1'b0;
    o_adrSrc            = 1'b0;
    o_aluSrcA           = 2'b00;
    o_aluSrcB           = 2'b00;
    o_resultSrc         = 2'b00;
    o_aluLogicOperation = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        ir_write    = 1'b1;
        pc_write    = 1'b1;
        o_aluSrcB   = 2'b10;
        o_resultSrc = 2'b10;
      end
      S_DECODE: begin
        o_aluSrcA = 2'b01;
        o_aluSrcB = 2'b01;
      end
      S_MEMADR: begin
        o_aluSrcA = 2'b10;
        o_aluSrcB = 2'b01;
      end
      S_MEMREAD:  o_adrSrc = 1'b1;
      S_MEMWB: begin
        o_resultSrc = 2'b01;
        reg_write   = 1'b1;
      end
      S_MEMWRITE: begin
        o_adrSrc  = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        o_aluSrcA           = 2'b10;
        o_aluLogicOperation = alu_dec;
      end
      S_ALUWB:    reg_write = 1'b1;
      S_EXECI: begin
        o_aluSrcA           = 2'b10;
        o_aluSrcB           = 2'b01;
        o_aluLogicOperation = alu_dec;
      end
      S_JAL: begin
        o_aluSrcA = 2'b01;
        o_aluSrcB = 2'b10;
        pc_write  = 1'b1;
      end
      S_BEQ: begin
        o_aluSrcA           = 2'b10;
        o_aluLogicOperation = ALU_SUB;
        pc_write            = i_zeroFlag;
      end
      default: ;
    endcase
  end

  // Reset is async and state_q already sits at FETCH, so only the strobes need
  // masking to keep them quiet while reset is held.
  assign o_pcWrite  = pc_write  & i_arst_n;
  assign o_irWrite  = ir_write  & i_arst_n;
  assign o_regWrite = reg_write & i_arst_n;
  assign o_memWrite = mem_write & i_arst_n;
  assign o_illegal  = (state_q == S_DECODE) & ~legal_instr & i_arst_n;
  assign o_state    = state_q;

  always_comb begin
    o_immSrc = 2'b00;
    if (is_store)    o_immSrc = 2'b01;
    else if (is_beq) o_immSrc = 2'b10;
    else if (is_jal) o_immSrc = 2'b11;
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed check of the multicycle controller, one output vector per cycle.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// Expected vectors are hand-written from the per-state output table.
module tb_multicycle_ctrl;
  import pa_riscv::*;

  logic       i_clk = 1'b0;
  logic       i_arst_n = 1'b0;
  logic [6:0] i_op = 7'b0000000;
  logic [2:0] i_funct3 = 3'b000;
  logic       i_funct7b5 = 1'b0;
  logic       i_zeroFlag = 1'b0;
  logic       o_pcWrite, o_irWrite, o_regWrite, o_memWrite, o_adrSrc, o_illegal;
  logic [1:0] o_aluSrcA, o_aluSrcB, o_resultSrc, o_immSrc;
  logic [3:0] o_aluLogicOperation, o_state;

  int n_checks = 0;
  int n_errors = 0;

  multicycle_ctrl dut (
    .i_clk(i_clk), .i_arst_n(i_arst_n), .i_op(i_op), .i_funct3(i_funct3),
    .i_funct7b5(i_funct7b5), .i_zeroFlag(i_zeroFlag),
    .o_pcWrite(o_pcWrite), .o_irWrite(o_irWrite), .o_regWrite(o_regWrite),
    .o_memWrite(o_memWrite), .o_adrSrc(o_adrSrc), .o_aluSrcA(o_aluSrcA),
    .o_aluSrcB(o_aluSrcB), .o_resultSrc(o_resultSrc), .o_immSrc(o_immSrc),
    .o_aluLogicOperation(o_aluLogicOperation), .o_illegal(o_illegal), .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  // {pcWrite, irWrite, regWrite, memWrite, adrSrc, aluSrcA, aluSrcB, resultSrc, aluop, illegal, state}
  logic [19:0] obs;
  assign obs = {o_pcWrite, o_irWrite, o_regWrite, o_memWrite, o_adrSrc, o_aluSrcA,
                o_aluSrcB, o_resultSrc, o_aluLogicOperation, o_illegal, o_state};

  function automatic logic [19:0] ev(input logic pc, ir, rw, mw, adr,
                                     input logic [1:0] a, b, res,
                                     input logic [3:0] alu, input logic ill,
                                     input logic [3:0] st);
    return {pc, ir, rw, mw, adr, a, b, res, alu, ill, st};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // check the current cycle, then move to the next falling edge
  task automatic cyc(input string tag, input logic [19:0] exp);
    #1 check(tag, {12'h0, obs}, {12'h0, exp});
    @(negedge i_clk);
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    i_op = op; i_funct3 = f3; i_funct7b5 = f7;
  endtask

  logic [19:0] V_RST, V_F, V_D, V_DILL, V_MA, V_MR, V_MWB, V_MWR, V_AWB, V_J;

  initial begin
    V_RST  = ev(0,0,0,0,0, 2'b00,2'b10,2'b10, ALU_ADD, 0, 4'd0);
    V_F    = ev(1,1,0,0,0, 2'b00,2'b10,2'b10, ALU_ADD, 0, 4'd0);
    V_D    = ev(0,0,0,0,0, 2'b01,2'b01,2'b00, ALU_ADD, 0, 4'd1);
    V_DILL = ev(0,0,0,0,0, 2'b01,2'b01,2'b00, ALU_ADD, 1, 4'd1);
    V_MA   = ev(0,0,0,0,0, 2'b10,2'b01,2'b00, ALU_ADD, 0, 4'd2);
    V_MR   = ev(0,0,0,0,1, 2'b00,2'b00,2'b00, ALU_ADD, 0, 4'd3);
    V_MWB  = ev(0,0,1,0,0, 2'b00,2'b00,2'b01, ALU_ADD, 0, 4'd4);
    V_MWR  = ev(0,0,0,1,1, 2'b00,2'b00,2'b00, ALU_ADD, 0, 4'd5);
    V_AWB  = ev(0,0,1,0,0, 2'b00,2'b00,2'b00, ALU_ADD, 0, 4'd7);
    V_J    = ev(1,0,0,0,0, 2'b01,2'b10,2'b00, ALU_ADD, 0, 4'd9);

    // reset held across clock edges
    repeat (2) @(negedge i_clk);
    cyc("reset", V_RST);
    i_arst_n = 1'b1;

    // lw
    set_instr(7'b0000011, 3'b010, 1'b0);
    #1 check("lw_imm", {30'h0, o_immSrc}, 32'd0);
    cyc("lw_fetch", V_F);
    cyc("lw_decode", V_D);
    cyc("lw_memadr", V_MA);
    cyc("lw_memread", V_MR);
    cyc("lw_memwb", V_MWB);

    // sw
    set_instr(7'b0100011, 3'b010, 1'b0);
    #1 check("sw_imm", {30'h0, o_immSrc}, 32'd1);
    cyc("sw_fetch", V_F);
    cyc("sw_decode", V_D);
    cyc("sw_memadr", V_MA);
    cyc("sw_memwrite", V_MWR);

    // R-type sub
    set_instr(7'b0110011, 3'b000, 1'b1);
    cyc("sub_fetch", V_F);
    cyc("sub_decode", V_D);
    cyc("sub_execr", ev(0,0,0,0,0, 2'b10,2'b00,2'b00, ALU_SUB, 0, 4'd6));
    cyc("sub_aluwb", V_AWB);

    // R-type and, or
    set_instr(7'b0110011, 3'b111, 1'b0);
    cyc("and_fetch", V_F);
    cyc("and_decode", V_D);
    cyc("and_execr", ev(0,0,0,0,0, 2'b10,2'b00,2'b00, ALU_AND, 0, 4'd6));
    cyc("and_aluwb", V_AWB);
    set_instr(7'b0110011, 3'b110, 1'b0);
    cyc("or_fetch", V_F);
    cyc("or_decode", V_D);
    cyc("or_execr", ev(0,0,0,0,0, 2'b10,2'b00,2'b00, ALU_OR, 0, 4'd6));
    cyc("or_aluwb", V_AWB);

    // addi with bit 30 set stays ADD
    set_instr(7'b0010011, 3'b000, 1'b1);
    #1 check("addi_imm", {30'h0, o_immSrc}, 32'd0);
    cyc("addi_fetch", V_F);
    cyc("addi_decode", V_D);
    cyc("addi_execi", ev(0,0,0,0,0, 2'b10,2'b01,2'b00, ALU_ADD, 0, 4'd8));
    cyc("addi_aluwb", V_AWB);

    // xori, slti
    set_instr(7'b0010011, 3'b100, 1'b0);
    cyc("xori_fetch", V_F);
    cyc("xori_decode", V_D);
    cyc("xori_execi", ev(0,0,0,0,0, 2'b10,2'b01,2'b00, ALU_XOR, 0, 4'd8));
    cyc("xori_aluwb", V_AWB);
    set_instr(7'b0010011, 3'b010, 1'b0);
    cyc("slti_fetch", V_F);
    cyc("slti_decode", V_D);
    cyc("slti_execi", ev(0,0,0,0,0, 2'b10,2'b01,2'b00, ALU_SLT, 0, 4'd8));
    cyc("slti_aluwb", V_AWB);

    // jal
    set_instr(7'b1101111, 3'b000, 1'b0);
    #1 check("jal_imm", {30'h0, o_immSrc}, 32'd3);
    cyc("jal_fetch", V_F);
    cyc("jal_decode", V_D);
    cyc("jal_jal", V_J);
    cyc("jal_aluwb", V_AWB);

    // beq taken, then zero flag dropped mid-state (pcWrite follows combinationally)
    set_instr(7'b1100011, 3'b000, 1'b0);
    #1 check("beq_imm", {30'h0, o_immSrc}, 32'd2);
    i_zeroFlag = 1'b1;
    cyc("beqt_fetch", V_F);
    cyc("beqt_decode", V_D);
    #1 check("beqt_beq", {12'h0, obs},
             {12'h0, ev(1,0,0,0,0, 2'b10,2'b00,2'b00, ALU_SUB, 0, 4'd10)});
    i_zeroFlag = 1'b0;
    cyc("beq_zdrop", ev(0,0,0,0,0, 2'b10,2'b00,2'b00, ALU_SUB, 0, 4'd10));
    // beq not taken
    cyc("beqn_fetch", V_F);
    cyc("beqn_decode", V_D);
    cyc("beqn_beq", ev(0,0,0,0,0, 2'b10,2'b00,2'b00, ALU_SUB, 0, 4'd10));

    // illegal opcode, bad lw funct3, bad beq funct3, bad R funct3
    set_instr(7'b1111111, 3'b000, 1'b0);
    cyc("ill_op_fetch", V_F);
    cyc("ill_op_decode", V_DILL);
    set_instr(7'b0000011, 3'b000, 1'b0);
    cyc("ill_lw_fetch", V_F);
    cyc("ill_lw_decode", V_DILL);
    set_instr(7'b1100011, 3'b001, 1'b0);
    cyc("ill_beq_fetch", V_F);
    cyc("ill_beq_decode", V_DILL);
    set_instr(7'b0110011, 3'b001, 1'b0);
    cyc("ill_r_fetch", V_F);
    cyc("ill_r_decode", V_DILL);

    // sw aborted by reset pulse in MEMADR
    set_instr(7'b0100011, 3'b010, 1'b0);
    cyc("swr_fetch", V_F);
    cyc("swr_decode", V_D);
    #1 check("swr_memadr", {12'h0, obs}, {12'h0, V_MA});
    i_arst_n = 1'b0;
    cyc("swr_inreset", V_RST);
    cyc("swr_held", V_RST);
    i_arst_n = 1'b1;
    cyc("swr_release", V_F);
    cyc("swr_decode2", V_D);
    cyc("swr_memadr2", V_MA);
    cyc("swr_memwrite2", V_MWR);
    cyc("final_fetch", V_F);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
